otp_ctrl_prog_chk: RTL and testbench



---
 rtl/lc_ctrl_pkg.sv | 14 +
 rtl/otp_ctrl_pkg.sv | 11 +
 rtl/prim_otp_pkg.sv | 17 +
 rtl/otp_ctrl_prog_chk.sv | 256 +++++++++++++++++++++++++
 tb/tb_otp_ctrl_prog_chk.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc_ctrl_pkg.sv
// Life cycle multi-bit signal type and its loose decode.
package lc_ctrl_pkg;

  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

  // Anything other than the exact Off pattern counts as asserted.
  function automatic logic lc_tx_test_true_loose(lc_tx_t val);
    return val != Off;
  endfunction

endpackage : lc_ctrl_pkg

// File: rtl/otp_ctrl_pkg.sv
// OTP controller widths and constants used by the program-check stage.
package otp_ctrl_pkg;

  localparam int OtpWidth          = 16;
  localparam int OtpSizeWidth      = 2;
  localparam int OtpIfWidth        = (1 << OtpSizeWidth) * OtpWidth;
  localparam int OtpAddrWidth      = 11;
  localparam int ScrmblBlockWidth  = 64;
  localparam int ProgChkStateWidth = 10;

endpackage : otp_ctrl_pkg

// File: rtl/prim_otp_pkg.sv
// OTP macro command and error types shared by all macro clients.
package prim_otp_pkg;

  typedef enum logic {
    Read  = 1'b0,
    Write = 1'b1
  } cmd_e;

  typedef enum logic [2:0] {
    NoError              = 3'h0,
    MacroError           = 3'h1,
    MacroEccCorrError    = 3'h2,
    MacroEccUncorrError  = 3'h3,
    MacroWriteBlankError = 3'h4
  } err_e;

endpackage : prim_otp_pkg

// File: rtl/otp_ctrl_prog_chk.sv
// Blank-check guard in front of the OTP macro command port: single-word writes are
// pre-read and refused if they would clear a programmed bit. Optional read-back
// verify is compiled in with `define OTP_CTRL_PROG_VERIFY_EN.

`ifndef PRIM_FLOP_SPARSE_FSM
`define PRIM_FLOP_SPARSE_FSM(__name, __d, __q, __type, __resval) \
  always_ff @(posedge clk_i or negedge rst_ni) begin : __name \
    if (!rst_ni) __q <= __type'(__resval); \
    else __q <= __d; \
  end
`endif

module otp_ctrl_prog_chk
  import otp_ctrl_pkg::*;
  import prim_otp_pkg::*;
  import lc_ctrl_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  lc_tx_t                      escalate_en_i,
  input  logic                        req_i,
  input  cmd_e                        cmd_i,
  input  logic [OtpSizeWidth-1:0]     size_i,
  input  logic [OtpIfWidth-1:0]       wdata_i,
  input  logic [OtpAddrWidth-1:0]     addr_i,
  output logic                        gnt_o,
  output logic                        rvalid_o,
  output logic [ScrmblBlockWidth-1:0] rdata_o,
  output err_e                        err_o,
  output logic                        otp_req_o,
  output cmd_e                        otp_cmd_o,
  output logic [OtpSizeWidth-1:0]     otp_size_o,
  output logic [OtpIfWidth-1:0]       otp_wdata_o,
  output logic [OtpAddrWidth-1:0]     otp_addr_o,
  input  logic                        otp_gnt_i,
  input  logic                        otp_rvalid_i,
  input  logic [ScrmblBlockWidth-1:0] otp_rdata_i,
  input  err_e                        otp_err_i,
  output logic                        fsm_err_o,
  output logic                        idle_o
);

  // Handshakes: upstream req_i is taken in the cycle gnt_o is high; the response
  // is a single rvalid_o pulse. Toward the macro, otp_req_o and all command fields
  // stay stable until otp_gnt_i, and otp_rvalid_i later returns exactly one response.

  // 10-bit words, pairwise Hamming distance >= 5.
  typedef enum logic [ProgChkStateWidth-1:0] {
    IdleSt      = 10'b1000111010,
    RdSt        = 10'b0001110100,
    RdWaitSt    = 10'b0011101001,
    PreRdSt     = 10'b0111010010,
    PreRdWaitSt = 10'b1110100100,
    WrSt        = 10'b1101001000,
    WrWaitSt    = 10'b1010010001,
`ifdef OTP_CTRL_PROG_VERIFY_EN
    VfySt       = 10'b0100100011,
    VfyWaitSt   = 10'b1001000111,
`endif
    ErrorSt     = 10'b0010001110
  } state_e;

  state_e state_d, state_q;

  cmd_e                        cmd_d, cmd_q;
  logic [OtpSizeWidth-1:0]     size_d, size_q;
  logic [OtpIfWidth-1:0]       wdata_d, wdata_q;
  logic [OtpAddrWidth-1:0]     addr_d, addr_q;
  logic [OtpWidth-1:0]         pre_d, pre_q;
  err_e                        pre_err_d, pre_err_q;
  logic                        rvalid_d, rvalid_q;
  logic [ScrmblBlockWidth-1:0] rdata_d, rdata_q;
  err_e                        err_d, err_q;

  logic [OtpWidth-1:0] rd_word, wr_word, conflict;
  err_e                wr_rsp_err;

  assign rd_word    = otp_rdata_i[OtpWidth-1:0];
  assign wr_word    = wdata_q[OtpWidth-1:0];
  assign conflict   = rd_word & ~wr_word;
  assign wr_rsp_err = (otp_err_i != NoError) ? otp_err_i : pre_err_q;

  always_comb begin
    state_d     = state_q;
    gnt_o       = 1'b0;
    idle_o      = 1'b0;
    fsm_err_o   = 1'b0;
    otp_req_o   = 1'b0;
    otp_cmd_o   = Read;
    otp_size_o  = '0;
    otp_wdata_o = '0;
    otp_addr_o  = '0;
    cmd_d       = cmd_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    pre_d       = pre_q;
    pre_err_d   = pre_err_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      IdleSt: begin
        idle_o = 1'b1;
        // The response cycle itself is still busy; grants resume one cycle later.
        if (req_i && !rvalid_q) begin
          gnt_o   = 1'b1;
          cmd_d   = cmd_i;
          size_d  = size_i;
          wdata_d = wdata_i;
          addr_d  = addr_i;
          if (cmd_i == Read) begin
            state_d = RdSt;
          end else if (size_i == '0) begin
            state_d = PreRdSt;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            err_d    = MacroError;
          end
        end
      end
      RdSt: begin
        otp_req_o  = 1'b1;
        otp_cmd_o  = cmd_q;
        otp_size_o = size_q;
        otp_addr_o = addr_q;
        if (otp_gnt_i) state_d = RdWaitSt;
      end
      RdWaitSt: begin
        if (otp_rvalid_i) begin
          rvalid_d = 1'b1;
          rdata_d  = otp_rdata_i;
          err_d    = otp_err_i;
          state_d  = IdleSt;
        end
      end
      PreRdSt: begin
        otp_req_o  = 1'b1;
        otp_addr_o = addr_q;
        if (otp_gnt_i) state_d = PreRdWaitSt;
      end
      PreRdWaitSt: begin
        if (otp_rvalid_i) begin
          pre_d     = rd_word;
          pre_err_d = otp_err_i;
          rdata_d   = '0;
          state_d   = IdleSt;
          rvalid_d  = 1'b1;
          if (otp_err_i == MacroEccUncorrError || otp_err_i == MacroError) begin
            err_d = otp_err_i;
          end else if (conflict != '0) begin
            err_d = MacroWriteBlankError;
          end else if (wr_word == rd_word) begin
            err_d = otp_err_i;
          end else begin
            rvalid_d = 1'b0;
            state_d  = WrSt;
          end
        end
      end
      WrSt: begin
        otp_req_o   = 1'b1;
        otp_cmd_o   = Write;
        otp_wdata_o = wdata_q;
        otp_addr_o  = addr_q;
        if (otp_gnt_i) state_d = WrWaitSt;
      end
      WrWaitSt: begin
        if (otp_rvalid_i) begin
          rdata_d = '0;
`ifdef OTP_CTRL_PROG_VERIFY_EN
          if (otp_err_i == NoError) begin
            state_d = VfySt;
          end else begin
            rvalid_d = 1'b1;
            err_d    = wr_rsp_err;
            state_d  = IdleSt;
          end
`else
          rvalid_d = 1'b1;
          err_d    = wr_rsp_err;
          state_d  = IdleSt;
`endif
        end
      end
`ifdef OTP_CTRL_PROG_VERIFY_EN
      VfySt: begin
        otp_req_o  = 1'b1;
        otp_addr_o = addr_q;
        if (otp_gnt_i) state_d = VfyWaitSt;
      end
      VfyWaitSt: begin
        if (otp_rvalid_i) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          state_d  = IdleSt;
          if ((otp_err_i != NoError && otp_err_i != MacroEccCorrError) ||
              rd_word != (pre_q | wr_word)) begin
            err_d = MacroError;
          end else begin
            err_d = otp_err_i;
          end
        end
      end
`endif
      ErrorSt: ;
      default: begin
        state_d   = ErrorSt;
        fsm_err_o = 1'b1;
      end
    endcase

    // Escalation overrides everything, including a response landing this cycle.
    if (lc_tx_test_true_loose(escalate_en_i) && state_q != ErrorSt) begin
      state_d   = ErrorSt;
      fsm_err_o = 1'b1;
      gnt_o     = 1'b0;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;
    end
  end

  `PRIM_FLOP_SPARSE_FSM(u_state_regs, state_d, state_q, state_e, IdleSt)

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_q     <= Read;
      size_q    <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      pre_q     <= '0;
      pre_err_q <= NoError;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= NoError;
    end else begin
      cmd_q     <= cmd_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      addr_q    <= addr_d;
      pre_q     <= pre_d;
      pre_err_q <= pre_err_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule : otp_ctrl_prog_chk

// File: tb/tb_otp_ctrl_prog_chk.sv
// Self-checking bench for otp_ctrl_prog_chk: directed and random transactions against
// a response-level reference model, a macro responder, and an escalation scenario.
module tb_otp_ctrl_prog_chk;
  import otp_ctrl_pkg::*;
  import prim_otp_pkg::*;
  import lc_ctrl_pkg::*;

  localparam int MacW = 1 + OtpAddrWidth + OtpSizeWidth + OtpIfWidth;
  localparam int RspW = 3 + ScrmblBlockWidth;

  logic                        clk_i;
  logic                        rst_ni;
  lc_tx_t                      escalate_en_i;
  logic                        req_i;
  cmd_e                        cmd_i;
  logic [OtpSizeWidth-1:0]     size_i;
  logic [OtpIfWidth-1:0]       wdata_i;
  logic [OtpAddrWidth-1:0]     addr_i;
  logic                        gnt_o;
  logic                        rvalid_o;
  logic [ScrmblBlockWidth-1:0] rdata_o;
  err_e                        err_o;
  logic                        otp_req_o;
  cmd_e                        otp_cmd_o;
  logic [OtpSizeWidth-1:0]     otp_size_o;
  logic [OtpIfWidth-1:0]       otp_wdata_o;
  logic [OtpAddrWidth-1:0]     otp_addr_o;
  logic                        otp_gnt_i;
  logic                        otp_rvalid_i;
  logic [ScrmblBlockWidth-1:0] otp_rdata_i;
  err_e                        otp_err_i;
  logic                        fsm_err_o;
  logic                        idle_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int gnt_dly_max = 0;
  int rv_dly_min = 0;
  int rv_dly_max = 0;

  logic [RspW-1:0] exp_q[$];
  logic [MacW-1:0] exp_mac_q[$];
  logic [MacW-1:0] act_mac_q[$];
  logic [RspW-1:0] mac_resp_q[$];

  otp_ctrl_prog_chk u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .escalate_en_i(escalate_en_i),
    .req_i        (req_i),
    .cmd_i        (cmd_i),
    .size_i       (size_i),
    .wdata_i      (wdata_i),
    .addr_i       (addr_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .otp_req_o    (otp_req_o),
    .otp_cmd_o    (otp_cmd_o),
    .otp_size_o   (otp_size_o),
    .otp_wdata_o  (otp_wdata_o),
    .otp_addr_o   (otp_addr_o),
    .otp_gnt_i    (otp_gnt_i),
    .otp_rvalid_i (otp_rvalid_i),
    .otp_rdata_i  (otp_rdata_i),
    .otp_err_i    (otp_err_i),
    .fsm_err_o    (fsm_err_o),
    .idle_o       (idle_o)
  );

  // Clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Macro responder: grants after a random delay, answers from mac_resp_q in order.
  initial begin : macro_agent
    logic [MacW-1:0] cmd_w;
    logic [RspW-1:0] rsp;
    int d;
    otp_gnt_i    = 1'b0;
    otp_rvalid_i = 1'b0;
    otp_rdata_i  = '0;
    otp_err_i    = NoError;
    @(negedge clk_i);
    forever begin
      if (otp_req_o) begin
        cmd_w = {otp_cmd_o, otp_addr_o, otp_size_o, otp_wdata_o};
        act_mac_q.push_back(cmd_w);
        d = $urandom_range(0, gnt_dly_max);
        repeat (d) begin
          @(negedge clk_i);
          check("mac_stable", {otp_req_o, otp_cmd_o, otp_addr_o, otp_size_o, otp_wdata_o},
                {1'b1, cmd_w});
        end
        otp_gnt_i = 1'b1;
        @(negedge clk_i);
        otp_gnt_i = 1'b0;
        d = $urandom_range(rv_dly_min, rv_dly_max);
        repeat (d) @(negedge clk_i);
        rsp = (mac_resp_q.size() > 0) ? mac_resp_q.pop_front() : '0;
        otp_rvalid_i = 1'b1;
        otp_err_i    = err_e'(rsp[RspW-1 -: 3]);
        otp_rdata_i  = rsp[ScrmblBlockWidth-1:0];
        @(negedge clk_i);
        otp_rvalid_i = 1'b0;
        otp_rdata_i  = '0;
        otp_err_i    = NoError;
      end else begin
        @(negedge clk_i);
      end
    end
  end

  // Reference model: from the transaction and the values the macro will return, derive
  // the macro commands that must appear and the single upstream response.
  task automatic ref_model(input cmd_e c, input logic [OtpSizeWidth-1:0] sz,
                           input logic [OtpIfWidth-1:0] wd, input logic [OtpAddrWidth-1:0] ad,
                           input logic [63:0] r0d, input err_e r0e, input err_e we,
                           input logic [63:0] vd, input err_e ve);
    logic [OtpWidth-1:0] pre, w;
    logic [RspW-1:0] rsp;
    int cleared;
    pre = r0d[OtpWidth-1:0];
    w   = wd[OtpWidth-1:0];
    cleared = 0;
    for (int i = 0; i < OtpWidth; i++) if (pre[i] && !w[i]) cleared++;
    if (c == Read) begin
      exp_mac_q.push_back({Read, ad, sz, {OtpIfWidth{1'b0}}});
      mac_resp_q.push_back({r0e, r0d});
      rsp = {r0e, r0d};
    end else if (sz != 0) begin
      rsp = {MacroError, 64'h0};
    end else begin
      exp_mac_q.push_back({Read, ad, {OtpSizeWidth{1'b0}}, {OtpIfWidth{1'b0}}});
      mac_resp_q.push_back({r0e, r0d});
      if (r0e == MacroError || r0e == MacroEccUncorrError) rsp = {r0e, 64'h0};
      else if (cleared > 0) rsp = {MacroWriteBlankError, 64'h0};
      else if (w == pre) rsp = {r0e, 64'h0};
      else begin
        exp_mac_q.push_back({Write, ad, {OtpSizeWidth{1'b0}}, wd});
        mac_resp_q.push_back({we, 64'h0});
        if (we != NoError) rsp = {we, 64'h0};
        else begin
`ifdef OTP_CTRL_PROG_VERIFY_EN
          exp_mac_q.push_back({Read, ad, {OtpSizeWidth{1'b0}}, {OtpIfWidth{1'b0}}});
          mac_resp_q.push_back({ve, vd});
          if ((ve != NoError && ve != MacroEccCorrError) || vd[OtpWidth-1:0] != (pre | w))
            rsp = {MacroError, 64'h0};
          else
            rsp = {ve, 64'h0};
`else
          rsp = {r0e, 64'h0};
`endif
        end
      end
    end
    exp_q.push_back(rsp);
  endtask

  // Driver: one upstream transaction, then compare response, latency and macro log.
  task automatic run_txn(input cmd_e c, input logic [OtpSizeWidth-1:0] sz,
                         input logic [OtpIfWidth-1:0] wd, input logic [OtpAddrWidth-1:0] ad,
                         input logic [63:0] r0d, input err_e r0e, input err_e we,
                         input logic [63:0] vd, input err_e ve, input int exp_lat);
    int t0;
    bit got;
    logic [RspW-1:0] exp_rsp;
    logic [MacW-1:0] em, am;
    ref_model(c, sz, wd, ad, r0d, r0e, we, vd, ve);
    act_mac_q.delete();
    @(negedge clk_i);
    req_i = 1'b1; cmd_i = c; size_i = sz; wdata_i = wd; addr_i = ad;
    got = 0;
    t0 = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (gnt_o) begin got = 1; t0 = cyc; break; end
      @(negedge clk_i);
    end
    check("gnt_seen", {127'h0, got}, 128'h1);
    @(negedge clk_i);
    req_i = 1'b0;
    cmd_i = cmd_e'($urandom_range(0, 1));
    size_i = OtpSizeWidth'($urandom);
    wdata_i = {$urandom, $urandom};
    addr_i = OtpAddrWidth'($urandom);
    exp_rsp = exp_q.pop_front();
    if (got) begin
      got = 0;
      for (int k = 0; k < 400; k++) begin
        if (rvalid_o) begin got = 1; break; end
        @(negedge clk_i);
      end
      check("rvalid_seen", {127'h0, got}, 128'h1);
      if (got) begin
        check("rsp", {err_o, rdata_o}, exp_rsp);
        if (exp_lat >= 0) check("latency", cyc - t0, exp_lat);
        check("idle_at_rsp", idle_o, 1'b1);
        req_i = 1'b1;
        #1;
        check("gnt_busy", gnt_o, 1'b0);
        @(negedge clk_i);
        req_i = 1'b0;
        check("rvalid_pulse", rvalid_o, 1'b0);
        check("rsp_hold", {err_o, rdata_o}, exp_rsp);
      end
    end
    check("mac_count", act_mac_q.size(), exp_mac_q.size());
    while (exp_mac_q.size() > 0 && act_mac_q.size() > 0) begin
      em = exp_mac_q.pop_front();
      am = act_mac_q.pop_front();
      check("mac_cmd", am, em);
    end
    exp_mac_q.delete();
    mac_resp_q.delete();
  endtask

  function automatic err_e rand_rd_err();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return NoError;
    if (r < 8) return MacroEccCorrError;
    if (r < 9) return MacroEccUncorrError;
    return MacroError;
  endfunction

  initial begin : main
    cmd_e c;
    logic [OtpSizeWidth-1:0] sz;
    logic [OtpWidth-1:0] pre, w;
    logic [63:0] r0d, vd;
    err_e r0e, we, ve;
    int n_gnt, n_req, n_rv;
    bit seen;

    rst_ni = 1'b0;
    escalate_en_i = Off;
    req_i = 1'b0; cmd_i = Read; size_i = '0; wdata_i = '0; addr_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_gnt", gnt_o, 1'b0);
    check("rst_rvalid", rvalid_o, 1'b0);
    check("rst_rdata", rdata_o, 64'h0);
    check("rst_err", err_o, NoError);
    check("rst_otp_req", otp_req_o, 1'b0);
    check("rst_otp_cmd", otp_cmd_o, Read);
    check("rst_otp_fields", {otp_size_o, otp_wdata_o, otp_addr_o}, '0);
    check("rst_idle", idle_o, 1'b1);
    check("rst_fsm_err", fsm_err_o, 1'b0);
    rst_ni = 1'b1;

    // Directed, zero-wait macro
    run_txn(Read, 2'd0, 64'h0, 11'h010, 64'hDEAD_BEEF, NoError, NoError, 64'h0, NoError, 3);
`ifdef OTP_CTRL_PROG_VERIFY_EN
    run_txn(Write, 2'd0, 64'h00F0, 11'h020, 64'h0030, NoError, NoError, 64'h00F0, NoError, 7);
    run_txn(Write, 2'd0, 64'h0101, 11'h021, 64'h0000, NoError, NoError, 64'h0100, NoError, 7);
`else
    run_txn(Write, 2'd0, 64'h00F0, 11'h020, 64'h0030, NoError, NoError, 64'h0, NoError, 5);
`endif
    run_txn(Write, 2'd0, 64'h000F, 11'h030, 64'h0030, NoError, NoError, 64'h0, NoError, 3);
    run_txn(Write, 2'd0, 64'h0030, 11'h040, 64'h0030, MacroEccCorrError, NoError, 64'h0,
            NoError, 3);
    run_txn(Write, 2'd0, 64'h00F0, 11'h050, 64'h0030, MacroEccUncorrError, NoError, 64'h0,
            NoError, 3);
    run_txn(Write, 2'd2, 64'h1234, 11'h060, 64'h0, NoError, NoError, 64'h0, NoError, 1);

    // Random, with macro wait states
    gnt_dly_max = 3; rv_dly_min = 0; rv_dly_max = 3;
    for (int n = 0; n < 60; n++) begin
      c = ($urandom_range(0, 3) == 0) ? Read : Write;
      sz = (c == Read || $urandom_range(0, 5) == 0) ? OtpSizeWidth'($urandom) : '0;
      pre = OtpWidth'($urandom);
      case ($urandom_range(0, 2))
        0: w = pre | OtpWidth'($urandom);
        1: w = pre;
        default: w = OtpWidth'($urandom);
      endcase
      r0d = {$urandom, 16'($urandom), pre};
      r0e = rand_rd_err();
      we = ($urandom_range(0, 4) == 0) ? MacroError : NoError;
      vd = ($urandom_range(0, 1) == 0) ? {48'($urandom), pre | w} : {$urandom, $urandom};
      ve = ($urandom_range(0, 3) == 0) ? rand_rd_err() : NoError;
      run_txn(c, sz, {$urandom, 16'($urandom), w}, OtpAddrWidth'($urandom), r0d, r0e, we, vd, ve,
              -1);
    end

    // Escalation landing together with the write response
    gnt_dly_max = 0; rv_dly_min = 0; rv_dly_max = 0;
    act_mac_q.delete();
    mac_resp_q.push_back({NoError, 64'h0030});
    mac_resp_q.push_back({NoError, 64'h0});
    @(negedge clk_i);
    req_i = 1'b1; cmd_i = Write; size_i = '0; wdata_i = 64'h00F0; addr_i = 11'h070;
    #1;
    check("esc_gnt", gnt_o, 1'b1);
    @(negedge clk_i);
    req_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (act_mac_q.size() == 2) begin seen = 1; break; end
      @(negedge clk_i);
    end
    check("esc_write_issued", {127'h0, seen}, 128'h1);
    @(negedge clk_i);
    escalate_en_i = lc_tx_t'(4'b0011);
    #1;
    check("esc_fsm_err", fsm_err_o, 1'b1);
    @(negedge clk_i);
    escalate_en_i = Off;
    #1;
    check("esc_pulse", fsm_err_o, 1'b0);
    check("esc_not_idle", idle_o, 1'b0);
    n_gnt = 0; n_req = 0; n_rv = 0;
    req_i = 1'b1; cmd_i = Read;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      #1;
      if (gnt_o) n_gnt++;
      if (otp_req_o) n_req++;
      if (rvalid_o) n_rv++;
    end
    req_i = 1'b0;
    check("esc_no_gnt", n_gnt, 0);
    check("esc_no_otp_req", n_req, 0);
    check("esc_no_rvalid", n_rv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_otp_ctrl_prog_chk
